load_unit: RTL and testbench

//  Executes decoded RV32I loads. Takes rs1 value, 12-bit offset, rd and 3-bit load_control from decode.

---
 rtl/load_unit_pkg.sv | 69 ++++++
 rtl/load_align_ext.sv | 45 ++++
 rtl/load_unit.sv | 153 +++++++++++++++
 tb/tb_load_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared types and helpers for the RV32I load unit: FSM state encoding,
// datapath widths, effective-address and alignment helpers.
// Load-control codes are the processor_defines.sv macros. They are guarded
// here so that this package compiles even when the defines file is absent.
`ifndef LB
`define LB     3'b000
`endif
`ifndef LH
`define LH     3'b001
`endif
`ifndef LW
`define LW     3'b010
`endif
`ifndef LBU
`define LBU    3'b100
`endif
`ifndef LHU
`define LHU    3'b101
`endif
`ifndef LD_NOP
`define LD_NOP 3'b111
`endif

package load_unit_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned IMM_W = 12;
   localparam int unsigned RD_W  = 5;
   localparam int unsigned CTL_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WB    = 3'd3,
      ST_ERR   = 3'd4,
      ST_DRAIN = 3'd5
   } ld_state_t;

   // Effective address: base plus sign-extended 12-bit offset, wrapping mod 2^32.
   function automatic logic [XLEN-1:0] calc_ea(input logic [XLEN-1:0]  base,
                                                input logic [IMM_W-1:0] off);
      return base + {{(XLEN-IMM_W){off[IMM_W-1]}}, off};
   endfunction

   // Word-aligned address that is presented to memory.
   function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] ea);
      return {ea[XLEN-1:2], 2'b00};
   endfunction

   // True for the five real load codes; LD_NOP and unlisted codes are dropped.
   function automatic logic is_load(input logic [CTL_W-1:0] ctl);
      case (ctl)
         `LB, `LH, `LW, `LBU, `LHU: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

   // Halfwords need EA[0]=0, words need EA[1:0]=0; bytes are always aligned.
   function automatic logic is_misaligned(input logic [1:0]       ea_lo,
                                          input logic [CTL_W-1:0] ctl);
      case (ctl)
         `LH, `LHU: return ea_lo[0];
         `LW:       return |ea_lo;
         default:   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load data aligner: selects the addressed byte or halfword lane from the
// returned memory word, then sign- or zero-extends it to 32 bits.
//  rdata   in  32  word returned by memory
//  ea_lo   in  2   low bits of the effective address
//  ctl     in  3   load_control code
//  data_c  out 32  extended result (combinational)
module load_align_ext
   import load_unit_pkg::*;
(
   input  logic [XLEN-1:0]  rdata,
   input  logic [1:0]       ea_lo,
   input  logic [CTL_W-1:0] ctl,
   output logic [XLEN-1:0]  data_c
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Lane selection by address offset.
   always_comb begin
      byte_lane = rdata[7:0];
      case (ea_lo)
         2'd0: byte_lane = rdata[7:0];
         2'd1: byte_lane = rdata[15:8];
         2'd2: byte_lane = rdata[23:16];
         2'd3: byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = ea_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Extension by load type.
   always_comb begin
      data_c = '0;
      case (ctl)
         `LB:  data_c = {{24{byte_lane[7]}}, byte_lane};
         `LBU: data_c = {24'h0, byte_lane};
         `LH:  data_c = {{16{half_lane[15]}}, half_lane};
         `LHU: data_c = {16'h0, half_lane};
         `LW:  data_c = rdata;
         default: data_c = '0;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// RV32I load unit: accepts one decoded load, issues a word-aligned read on the
// req/gnt/rvalid data-memory port, aligns/extends the returned lane and emits
// a single writeback beat. One load in flight; flush and timeout supported.
//  clk, rst_n          clock, async active-low reset
//  flush               kill the current load
//  ld_valid/ld_ready   load issue handshake (ld_ready is combinational)
//  load_control, rs1_val, imm, rd   decoded load
//  mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata   data-memory port
//  wb_valid/wb_rd/wb_data   writeback beat
//  ld_misalign, ld_fault    one-cycle error pulses
module load_unit
   import load_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [CTL_W-1:0] load_control,
   input  logic [XLEN-1:0]  rs1_val,
   input  logic [IMM_W-1:0] imm,
   input  logic [RD_W-1:0]  rd,
   output logic             mem_req,
   output logic [XLEN-1:0]  mem_addr,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic             wb_valid,
   output logic [RD_W-1:0]  wb_rd,
   output logic [XLEN-1:0]  wb_data,
   output logic             ld_misalign,
   output logic             ld_fault
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   ld_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             expired;
   logic             accept;
   logic [XLEN-1:0]  ea;
   logic [1:0]       ea_lo_q;
   logic [CTL_W-1:0] ctl_q;
   logic [RD_W-1:0]  rd_q;
   logic [XLEN-1:0]  ext_data;

   assign ld_ready = (state == ST_IDLE) && !flush && rst_n;
   assign accept   = ld_valid && ld_ready;
   assign ea       = calc_ea(rs1_val, imm);

   // Cycle budget for REQ+WAIT (and DRAIN after a flush).
   assign cnt_inc  = cnt + CNT_W'(1);
   assign expired  = (cnt_inc >= CNT_W'(TIMEOUT));

   load_align_ext u_align (
      .rdata  (mem_rdata),
      .ea_lo  (ea_lo_q),
      .ctl    (ctl_q),
      .data_c (ext_data)
   );

   // Load sequencing FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         wb_valid    <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         ld_misalign <= 1'b0;
         ld_fault    <= 1'b0;
         ea_lo_q     <= '0;
         ctl_q       <= `LD_NOP;
         rd_q        <= '0;
      end else begin
         wb_valid    <= 1'b0;
         ld_misalign <= 1'b0;
         ld_fault    <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Stray rvalid here belongs to an abandoned request; ignore it.
               if (accept && is_load(load_control)) begin
                  ea_lo_q <= ea[1:0];
                  ctl_q   <= load_control;
                  rd_q    <= rd;
                  if (is_misaligned(ea[1:0], load_control)) begin
                     ld_misalign <= 1'b1;
                     state       <= ST_ERR;
                  end else begin
                     mem_req  <= 1'b1;
                     mem_addr <= word_addr(ea);
                     cnt      <= '0;
                     state    <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               cnt <= cnt_inc;
               if (flush) begin
                  // A grant in the flush cycle leaves a response to drain.
                  mem_req <= 1'b0;
                  state   <= mem_gnt ? ST_DRAIN : ST_IDLE;
               end else if (expired) begin
                  mem_req  <= 1'b0;
                  ld_fault <= 1'b1;
                  state    <= ST_IDLE;
               end else if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt <= cnt_inc;
               if (flush) begin
                  state <= mem_rvalid ? ST_IDLE : ST_DRAIN;
               end else if (mem_rvalid) begin
                  // Data in hand wins over a coincident timeout.
                  wb_data  <= ext_data;
                  wb_rd    <= rd_q;
                  wb_valid <= 1'b1;
                  state    <= ST_WB;
               end else if (expired) begin
                  ld_fault <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            ST_WB: begin
               state <= ST_IDLE;
            end
            ST_ERR: begin
               state <= ST_IDLE;
            end
            ST_DRAIN: begin
               // Discard the flushed response; a timeout here is silent.
               cnt <= cnt_inc;
               if (mem_rvalid || expired) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               mem_req <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit.
`ifndef LB
`define LB     3'b000
`endif
`ifndef LH
`define LH     3'b001
`endif
`ifndef LW
`define LW     3'b010
`endif
`ifndef LBU
`define LBU    3'b100
`endif
`ifndef LHU
`define LHU    3'b101
`endif
`ifndef LD_NOP
`define LD_NOP 3'b111
`endif

module tb_load_unit;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        ld_valid;
   logic        ld_ready;
   logic [2:0]  load_control;
   logic [31:0] rs1_val;
   logic [11:0] imm;
   logic [4:0]  rd;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ld_misalign;
   logic        ld_fault;

   int checks;
   int failures;

   load_unit #(.TIMEOUT(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .load_control (load_control),
      .rs1_val      (rs1_val),
      .imm          (imm),
      .rd           (rd),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_gnt      (mem_gnt),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .ld_misalign  (ld_misalign),
      .ld_fault     (ld_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; sample and drive 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one load with grant in c1 and rvalid in c2; checks c0..c4.
   task automatic run_load(input logic [2:0] ctl, input logic [31:0] base,
                           input logic [11:0] off, input logic [4:0] dst,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data, input string name);
      ld_valid = 1'b1; load_control = ctl; rs1_val = base; imm = off; rd = dst;
      checks++;
      if (ld_ready !== 1'b1) begin
         failures++; $display("FAIL %s_ready: got %b expected 1", name, ld_ready);
      end
      step();
      ld_valid = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
         failures++;
         $display("FAIL %s_req: got req=%b addr=%h expected req=1 addr=%h",
                  name, mem_req, mem_addr, exp_addr);
      end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      checks++;
      if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_wait: got req=%b wb=%b expected 0 0", name, mem_req, wb_valid);
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      step();
      mem_rvalid = 1'b0;
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== exp_data || wb_rd !== dst || ld_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s_wb: got v=%b data=%h rd=%0d rdy=%b expected 1 %h %0d 0",
                  name, wb_valid, wb_data, wb_rd, ld_ready, exp_data, dst);
      end
      step();
      checks++;
      if (wb_valid !== 1'b0 || ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_done: got wb=%b rdy=%b expected 0 1", name, wb_valid, ld_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; ld_valid = 1'b0; load_control = `LD_NOP;
      rs1_val = '0; imm = '0; rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      step();
      checks++;
      if (ld_ready !== 1'b0) begin
         failures++; $display("FAIL reset_ready_low: got %b expected 0", ld_ready);
      end
      step();
      rst_n = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0 || wb_valid !== 1'b0 || wb_rd !== 5'd0 ||
          wb_data !== 32'h0 || ld_misalign !== 1'b0 || ld_fault !== 1'b0 || ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: got req=%b addr=%h wb=%b rd=%0d data=%h mis=%b flt=%b rdy=%b expected all 0, rdy=1",
                  mem_req, mem_addr, wb_valid, wb_rd, wb_data, ld_misalign, ld_fault, ld_ready);
      end
   endtask

   task automatic test_lw();
      run_load(`LW, 32'h1000, 12'h004, 5'd7, 32'hDEADBEEF, 32'h1004, 32'hDEADBEEF, "lw");
   endtask

   task automatic test_extract();
      run_load(`LB,  32'h2000, 12'h003, 5'd1, 32'h80112233, 32'h2000, 32'hFFFFFF80, "lb");
      run_load(`LBU, 32'h2000, 12'h003, 5'd2, 32'h80112233, 32'h2000, 32'h00000080, "lbu");
      run_load(`LH,  32'h2000, 12'h002, 5'd3, 32'h80112233, 32'h2000, 32'hFFFF8011, "lh");
      run_load(`LHU, 32'h2000, 12'h002, 5'd4, 32'h80112233, 32'h2000, 32'h00008011, "lhu");
      run_load(`LB,  32'h2000, 12'h001, 5'd5, 32'h80112233, 32'h2000, 32'h00000022, "lb1");
      run_load(`LH,  32'h2000, 12'h000, 5'd6, 32'h80112233, 32'h2000, 32'h00002233, "lh0");
   endtask

   task automatic test_neg_imm();
      run_load(`LW, 32'h10, 12'hFFC, 5'd9, 32'h12345678, 32'h0000000C, 32'h12345678, "negimm");
   endtask

   // Misaligned loads pulse ld_misalign and never raise mem_req.
   task automatic test_misalign();
      logic [2:0]  ctls  [2];
      logic [11:0] offs  [2];
      ctls[0] = `LH; offs[0] = 12'h001;
      ctls[1] = `LW; offs[1] = 12'h002;
      for (int k = 0; k < 2; k++) begin
         ld_valid = 1'b1; load_control = ctls[k]; rs1_val = 32'h10; imm = offs[k]; rd = 5'd8;
         step();
         ld_valid = 1'b0;
         checks++;
         if (ld_misalign !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL misalign_pulse%0d: got mis=%b req=%b expected 1 0", k, ld_misalign, mem_req);
         end
         for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (ld_misalign !== 1'b0 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin
               failures++;
               $display("FAIL misalign_after%0d_%0d: got mis=%b req=%b wb=%b expected 0 0 0",
                        k, c, ld_misalign, mem_req, wb_valid);
            end
         end
      end
   endtask

   // Grant delayed two cycles, rvalid one cycle after grant + 1 gap.
   task automatic test_stall();
      int req_cycles;
      ld_valid = 1'b1; load_control = `LHU; rs1_val = 32'h4000; imm = 12'h002; rd = 5'd11;
      step();
      ld_valid = 1'b0;
      req_cycles = 0;
      for (int c = 1; c <= 3; c++) begin
         if (mem_req === 1'b1 && mem_addr === 32'h4000) req_cycles++;
         if (c == 3) mem_gnt = 1'b1;
         step();
         mem_gnt = 1'b0;
      end
      checks++;
      if (req_cycles != 3) begin
         failures++; $display("FAIL stall_req_held: got %0d expected 3", req_cycles);
      end
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE1234;
      step();
      mem_rvalid = 1'b0;
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h0000CAFE || wb_rd !== 5'd11) begin
         failures++;
         $display("FAIL stall_wb: got v=%b data=%h rd=%0d expected 1 0000cafe 11", wb_valid, wb_data, wb_rd);
      end
      step();
   endtask

   // Grant never arrives: fault after 16 request cycles, stray rvalid ignored.
   task automatic test_timeout();
      int req_cycles;
      int fault_cycle;
      int fault_count;
      ld_valid = 1'b1; load_control = `LW; rs1_val = 32'h5000; imm = 12'h0; rd = 5'd12;
      step();
      ld_valid = 1'b0;
      req_cycles = 0; fault_cycle = -1; fault_count = 0;
      for (int c = 1; c <= 30; c++) begin
         if (mem_req === 1'b1) req_cycles++;
         if (ld_fault === 1'b1) begin
            fault_count++;
            if (fault_cycle < 0) fault_cycle = c;
            if (mem_req !== 1'b0) fault_count += 100;
         end
         if (c == 20) mem_rvalid = 1'b1;
         if (c == 20) mem_rdata = 32'h11111111;
         step();
         mem_rvalid = 1'b0;
         if (wb_valid === 1'b1) fault_count += 1000;
      end
      checks++;
      if (req_cycles != 16) begin
         failures++; $display("FAIL timeout_req_cycles: got %0d expected 16", req_cycles);
      end
      checks++;
      if (fault_cycle != 17 || fault_count != 1) begin
         failures++;
         $display("FAIL timeout_fault: got cycle=%0d code=%0d expected 17 1", fault_cycle, fault_count);
      end
      checks++;
      if (ld_ready !== 1'b1) begin
         failures++; $display("FAIL timeout_ready: got %b expected 1", ld_ready);
      end
   endtask

   // Flush in REQ without grant returns straight to IDLE.
   task automatic test_flush_req();
      ld_valid = 1'b1; load_control = `LW; rs1_val = 32'h6000; imm = 12'h0; rd = 5'd13;
      step();
      ld_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || ld_ready !== 1'b1 || wb_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_req: got req=%b rdy=%b wb=%b expected 0 1 0", mem_req, ld_ready, wb_valid);
      end
   endtask

   // Flush in WAIT, late response drained, then a fresh load writes back alone.
   task automatic test_flush_wait();
      int wb_seen;
      ld_valid = 1'b1; load_control = `LW; rs1_val = 32'h3000; imm = 12'h0; rd = 5'd14;
      step();
      ld_valid = 1'b0; mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      wb_seen = 0;
      for (int c = 3; c <= 5; c++) begin
         if (ld_ready !== 1'b0) wb_seen += 10;
         if (wb_valid === 1'b1) wb_seen++;
         if (c == 5) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
         end
         step();
         mem_rvalid = 1'b0;
      end
      if (wb_valid === 1'b1) wb_seen++;
      checks++;
      if (wb_seen != 0) begin
         failures++; $display("FAIL flush_drain: got code=%0d expected 0", wb_seen);
      end
      run_load(`LW, 32'h3000, 12'h008, 5'd15, 32'h600DF00D, 32'h3008, 32'h600DF00D, "after_flush");
   endtask

   // Reset asserted while waiting: outputs clear at once, late response ignored.
   task automatic test_reset_mid();
      ld_valid = 1'b1; load_control = `LW; rs1_val = 32'h7000; imm = 12'h0; rd = 5'd16;
      step();
      ld_valid = 1'b0; mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0 || wb_data !== 32'h0 || wb_rd !== 5'd0 ||
          wb_valid !== 1'b0 || ld_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: got req=%b addr=%h data=%h rd=%0d wb=%b rdy=%b expected 0 0 0 0 0 0",
                  mem_req, mem_addr, wb_data, wb_rd, wb_valid, ld_ready);
      end
      step();
      rst_n = 1'b1;
      #1;
      checks++;
      if (ld_ready !== 1'b1) begin
         failures++; $display("FAIL reset_release_ready: got %b expected 1", ld_ready);
      end
      mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
      step();
      mem_rvalid = 1'b0;
      step();
      checks++;
      if (wb_valid !== 1'b0 || wb_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_stray_rvalid: got wb=%b data=%h expected 0 0", wb_valid, wb_data);
      end
   endtask

   // LD_NOP and an unlisted code are consumed without any activity.
   task automatic test_nop();
      logic [2:0] codes [2];
      codes[0] = `LD_NOP;
      codes[1] = 3'b110;
      for (int k = 0; k < 2; k++) begin
         ld_valid = 1'b1; load_control = codes[k]; rs1_val = 32'h8001; imm = 12'h0; rd = 5'd17;
         checks++;
         if (ld_ready !== 1'b1) begin
            failures++; $display("FAIL nop_ready%0d: got %b expected 1", k, ld_ready);
         end
         step();
         ld_valid = 1'b0;
         for (int c = 0; c < 2; c++) begin
            checks++;
            if (mem_req !== 1'b0 || wb_valid !== 1'b0 || ld_misalign !== 1'b0 ||
                ld_fault !== 1'b0 || ld_ready !== 1'b1) begin
               failures++;
               $display("FAIL nop_idle%0d_%0d: got req=%b wb=%b mis=%b flt=%b rdy=%b expected 0 0 0 0 1",
                        k, c, mem_req, wb_valid, ld_misalign, ld_fault, ld_ready);
            end
            step();
         end
      end
   endtask

   // Two loads with the second accepted in the first's c4.
   task automatic test_back_to_back();
      run_load(`LW,  32'h9000, 12'h010, 5'd20, 32'hA5A5A5A5, 32'h9010, 32'hA5A5A5A5, "b2b0");
      run_load(`LBU, 32'h9000, 12'h012, 5'd21, 32'h00FE0000, 32'h9010, 32'h000000FE, "b2b1");
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_lw();
      test_extract();
      test_neg_imm();
      test_misalign();
      test_stall();
      test_timeout();
      test_flush_req();
      test_flush_wait();
      test_reset_mid();
      test_nop();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
